// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its return-address stack.
package branch_resolver_pkg;

  localparam int unsigned ADDR_W               = 32;
  localparam int unsigned RAS_DEPTH_DEFAULT    = 8;
  localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Resolved-branch input bundle and redirect/flush/status outputs of the branch resolver.
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic              br_valid;
  logic              br_taken;
  logic              br_call;
  logic              br_ret;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] br_link_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;
  logic              busy;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output br_valid, br_taken, br_call, br_ret, br_target, br_link_pc,
    input  redirect_valid, redirect_pc, flush, busy, ras_overflow, ras_underflow
  );

  modport slave (
    input  br_valid, br_taken, br_call, br_ret, br_target, br_link_pc,
    output redirect_valid, redirect_pc, flush, busy, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/branch_resolver_ras_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
module ras_stack
  import branch_resolver_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pushData,
  output logic [ADDR_W-1:0] topData,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;

  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign empty   = (count == '0);
  // ptr is the next write slot, so the top of stack sits one below it.
  assign topData = mem[ptr - 1'b1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= pushData;
  end

endmodule

// File: rtl/branch_resolver.sv
// Turns a resolved taken branch into a one-cycle PC redirect followed by a pipeline flush.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned RAS_DEPTH    = RAS_DEPTH_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  branch_resolver_if.slave  bus
);

  state_t            state;
  logic [3:0]        flushCnt;
  logic              redirectValidQ;
  logic [ADDR_W-1:0] redirectPcQ;
  logic              flushQ;
  logic              busyQ;
  logic              overflowQ;
  logic              underflowQ;

  logic              accept;
  logic              isRet;
  logic              rasPush;
  logic              rasPop;
  logic [ADDR_W-1:0] rasTop;
  logic              rasFull;
  logic              rasEmpty;

  // A call flag wins over a simultaneous return flag.
  assign accept  = (state == IDLE) && bus.br_valid && bus.br_taken;
  assign isRet   = bus.br_ret && !bus.br_call;
  assign rasPush = accept && bus.br_call;
  assign rasPop  = accept && isRet && !rasEmpty;

  ras_stack #(.RAS_DEPTH(RAS_DEPTH)) uRas (
    .clk      (clk),
    .reset    (reset),
    .push     (rasPush),
    .pop      (rasPop),
    .pushData (bus.br_link_pc),
    .topData  (rasTop),
    .full     (rasFull),
    .empty    (rasEmpty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      flushCnt       <= '0;
      redirectValidQ <= 1'b0;
      redirectPcQ    <= '0;
      flushQ         <= 1'b0;
      busyQ          <= 1'b0;
      overflowQ      <= 1'b0;
      underflowQ     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= REDIRECT;
            redirectValidQ <= 1'b1;
            flushQ         <= 1'b1;
            busyQ          <= 1'b1;
            redirectPcQ    <= rasPop ? rasTop : bus.br_target;
            overflowQ      <= rasPush && rasFull;
            underflowQ     <= accept && isRet && rasEmpty;
          end
        end
        REDIRECT: begin
          state          <= FLUSH;
          redirectValidQ <= 1'b0;
          overflowQ      <= 1'b0;
          underflowQ     <= 1'b0;
          flushCnt       <= 4'(FLUSH_CYCLES);
        end
        FLUSH: begin
          flushCnt <= flushCnt - 1'b1;
          if (flushCnt == 4'd1) begin
            state  <= IDLE;
            flushQ <= 1'b0;
            busyQ  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid = redirectValidQ;
  assign bus.redirect_pc    = redirectPcQ;
  assign bus.flush          = flushQ;
  assign bus.busy           = busyQ;
  assign bus.ras_overflow   = overflowQ;
  assign bus.ras_underflow  = underflowQ;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_resolver_if bus ();

  branch_resolver #(.RAS_DEPTH(8), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic t, input logic c, input logic r,
                       input logic [31:0] tgt, input logic [31:0] link);
    bus.br_valid   = v;
    bus.br_taken   = t;
    bus.br_call    = c;
    bus.br_ret     = r;
    bus.br_target  = tgt;
    bus.br_link_pc = link;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a branch for exactly one edge, then withdraw it.
  task automatic present(input logic c, input logic r, input logic [31:0] tgt, input logic [31:0] link);
    drive(1'b1, 1'b1, c, r, tgt, link);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic waitIdle();
    int unsigned n;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL waitIdle: busy=%b required 0 within 20 cycles", bus.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++;
    if ({bus.redirect_valid, bus.flush, bus.busy, bus.ras_overflow, bus.ras_underflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.redirect_valid, bus.flush, bus.busy, bus.ras_overflow, bus.ras_underflow});
    end
    checks++;
    if (bus.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h required 00000000", bus.redirect_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_not_taken();
    int unsigned bad;
    bad = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h44);
    for (int i = 0; i < 5; i++) begin
      step();
      if ({bus.redirect_valid, bus.flush, bus.busy} !== 3'b0) bad++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL not_taken: %0d cycles with activity, required 0", bad);
    end
    checks++;
    if (dut.uRas.count !== 4'd0) begin
      errors++;
      $display("FAIL not_taken_count: got %0d required 0", dut.uRas.count);
    end
  endtask

  task automatic test_taken();
    int unsigned nFlush, nBusy, nRv;
    present(1'b0, 1'b0, 32'h40, 32'h0);
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h40) begin
      errors++;
      $display("FAIL taken_redirect: rv=%b pc=%h required rv=1 pc=00000040",
               bus.redirect_valid, bus.redirect_pc);
    end
    nFlush = 1; nBusy = 1; nRv = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      nFlush += (bus.flush === 1'b1) ? 1 : 0;
      nBusy  += (bus.busy === 1'b1) ? 1 : 0;
      nRv    += (bus.redirect_valid === 1'b1) ? 1 : 0;
    end
    checks++;
    if (nFlush != 3 || nBusy != 3 || nRv != 1) begin
      errors++;
      $display("FAIL taken_timing: flush=%0d busy=%0d rv=%0d required 3 3 1", nFlush, nBusy, nRv);
    end
    checks++;
    if (bus.redirect_pc !== 32'h40) begin
      errors++;
      $display("FAIL taken_pc_hold: got %h required 00000040", bus.redirect_pc);
    end
  endtask

  task automatic test_call_return();
    present(1'b1, 1'b0, 32'h100, 32'h24);
    checks++;
    if (bus.redirect_pc !== 32'h100) begin
      errors++;
      $display("FAIL call_pc: got %h required 00000100", bus.redirect_pc);
    end
    waitIdle();
    present(1'b0, 1'b1, 32'h500, 32'h0);
    checks++;
    if (bus.redirect_pc !== 32'h24 || bus.ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL return_pc: pc=%h unf=%b required 00000024 0", bus.redirect_pc, bus.ras_underflow);
    end
    waitIdle();
    checks++;
    if (dut.uRas.count !== 4'd0) begin
      errors++;
      $display("FAIL return_count: got %0d required 0", dut.uRas.count);
    end
  endtask

  task automatic test_overflow_underflow();
    int unsigned badOvf, badPc;
    badOvf = 0;
    badPc  = 0;
    for (int i = 1; i <= 9; i++) begin
      present(1'b1, 1'b0, 32'h200, 32'(i));
      if (bus.ras_overflow !== ((i == 9) ? 1'b1 : 1'b0)) badOvf++;
      step();
      if (bus.ras_overflow !== 1'b0) badOvf++;
      waitIdle();
    end
    checks++;
    if (badOvf != 0) begin
      errors++;
      $display("FAIL overflow_pulse: %0d wrong samples, required 0", badOvf);
    end
    checks++;
    if (dut.uRas.count !== 4'd8) begin
      errors++;
      $display("FAIL overflow_count: got %0d required 8", dut.uRas.count);
    end
    for (int i = 1; i <= 8; i++) begin
      present(1'b0, 1'b1, 32'hFF, 32'h0);
      if (bus.redirect_pc !== 32'(10 - i) || bus.ras_underflow !== 1'b0) begin
        badPc++;
        $display("  return %0d: pc=%h expected %h", i, bus.redirect_pc, 32'(10 - i));
      end
      waitIdle();
    end
    checks++;
    if (badPc != 0) begin
      errors++;
      $display("FAIL return_sequence: %0d wrong returns, required 0", badPc);
    end
    present(1'b0, 1'b1, 32'hFF, 32'h0);
    checks++;
    if (bus.redirect_pc !== 32'hFF || bus.ras_underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow: pc=%h unf=%b required 000000ff 1", bus.redirect_pc, bus.ras_underflow);
    end
    step();
    checks++;
    if (bus.ras_underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_pulse_width: got %b required 0", bus.ras_underflow);
    end
    waitIdle();
  endtask

  task automatic test_busy_mask_and_reset();
    present(1'b0, 1'b0, 32'h40, 32'h0);
    step();
    // In FLUSH now: a call here must be ignored.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h88);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h40 || dut.uRas.count !== 4'd0) begin
      errors++;
      $display("FAIL busy_mask: rv=%b pc=%h count=%0d required 0 00000040 0",
               bus.redirect_valid, bus.redirect_pc, dut.uRas.count);
    end
    waitIdle();
    present(1'b0, 1'b0, 32'h60, 32'h0);
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.redirect_valid, bus.flush, bus.busy, bus.ras_overflow, bus.ras_underflow} !== 5'b0 ||
        bus.redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL mid_flush_reset: flags=%b pc=%h required 00000 00000000",
               {bus.redirect_valid, bus.flush, bus.busy, bus.ras_overflow, bus.ras_underflow},
               bus.redirect_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    present(1'b0, 1'b0, 32'h40, 32'h0);
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h40 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_branch: rv=%b pc=%h busy=%b required 1 00000040 1",
               bus.redirect_valid, bus.redirect_pc, bus.busy);
    end
    waitIdle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_not_taken();
    test_taken();
    test_call_return();
    test_overflow_underflow();
    test_busy_mask_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter RAS_DEPTH, default 8: number of return-address-stack entries (power of two).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2: number of flush cycles after the redirect cycle (1 to 15).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port br_valid, input, 1 bit: a resolved branch/jump is presented this cycle.
REQ-006 Port br_taken, input, 1 bit: comparator decision (branch taken).
REQ-007 Port br_call, input, 1 bit: comparator link flag (taken jump is a call).
REQ-008 Port br_ret, input, 1 bit: taken jump is a return; target comes from the stack.
REQ-009 Port br_target, input, 32 bits: computed branch/jump target.
REQ-010 Port br_link_pc, input, 32 bits: return address for a call.
REQ-011 Port redirect_valid, output, 1 bit: PC redirect strobe.
REQ-012 Port redirect_pc, output, 32 bits: new fetch PC, valid while redirect_valid=1.
REQ-013 Port flush, output, 1 bit: squash younger pipeline stages.
REQ-014 Port busy, output, 1 bit: block not accepting branches; upstream holds.
REQ-015 Port ras_overflow, output, 1 bit: one-cycle pulse when a push hits a full stack.
REQ-016 Port ras_underflow, output, 1 bit: one-cycle pulse when a pop hits an empty stack.

Function
REQ-017 The block SHALL implement FSM states IDLE, REDIRECT and FLUSH; busy=1 in every state except IDLE.
REQ-018 In IDLE, a qualified branch (br_valid=1 and br_taken=1) sampled on an edge SHALL move the FSM to REDIRECT.
  - Otherwise the FSM stays in IDLE with no stack change.
  - br_call and br_ret SHALL be ignored when br_taken=0.
REQ-019 In REDIRECT (exactly 1 cycle), the block SHALL drive redirect_valid=1 and flush=1; the FSM then goes to FLUSH.
REQ-020 In FLUSH, the block SHALL drive flush=1 and redirect_valid=0 for FLUSH_CYCLES cycles, counted by a down-counter, then return to IDLE.
  - Total flush per taken branch = 1 + FLUSH_CYCLES cycles.
REQ-021 Branch inputs (br_*) SHALL be ignored whenever busy=1.
REQ-022 redirect_pc SHALL be registered at the accepting edge and hold its value until the next accepted branch.
  - Selection: popped stack top if br_ret=1 and the stack is non-empty; br_target otherwise.
REQ-023 A call (br_call=1, qualified) SHALL push br_link_pc at the accepting edge, and redirect_pc SHALL be br_target.
REQ-024 A return (br_ret=1, br_call=0, qualified) SHALL pop at the accepting edge.
REQ-025 If br_call=1 and br_ret=1 together, the block SHALL perform the call only.
REQ-026 The stack SHALL be circular: a push when count=RAS_DEPTH overwrites the oldest entry and the write pointer wraps modulo RAS_DEPTH.
  - count stays at RAS_DEPTH.
  - ras_overflow pulses high for 1 cycle.
REQ-027 A pop when count=0 SHALL leave the pointer unchanged, use br_target, and pulse ras_underflow for 1 cycle.
REQ-028 ras_overflow and ras_underflow SHALL be asserted in the REDIRECT cycle only.

Reset
REQ-029 While reset=1, the block SHALL force, asynchronously: FSM=IDLE, flush counter=0, stack pointer=0, count=0.
REQ-030 While reset=1, all outputs SHALL be 0: redirect_valid, redirect_pc, flush, busy, ras_overflow, ras_underflow.
REQ-031 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abort the sequence immediately; stack contents are discarded.
REQ-032 Stack storage data need not be reset; only pointer and count are reset.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration, the default RAS_DEPTH and FLUSH_CYCLES constants, and the 32-bit address width constant.
REQ-034 The return-address stack SHALL be a separate sub-module, ras_stack, with push/pop/data/full/empty ports.
  - The FSM, flush counter and redirect mux stay in branch_resolver.

Verification
REQ-035 Not-taken branch: br_valid=1, br_taken=0 -> no redirect_valid, flush or busy for 5 cycles; stack count stays 0.
REQ-036 Plain taken branch: br_target=0x00000040 in IDLE -> next cycle redirect_valid=1 with redirect_pc=0x00000040; flush high for 3 cycles; busy high for 3 cycles.
REQ-037 Call then return:
  - Call with br_target=0x100, br_link_pc=0x24 -> redirect_pc=0x100.
  - After busy drops, a return -> redirect_pc=0x24; count back to 0.
REQ-038 Overflow/underflow:
  - 9 calls with link 1..9 -> ras_overflow pulse on the 9th call.
  - Then 8 returns -> redirect_pc 9,8,...,2.
  - A 9th return with br_target=0xFF -> redirect_pc=0xFF and an ras_underflow pulse.
REQ-039 Busy masking and reset: a second branch presented during FLUSH is ignored; reset asserted during FLUSH -> all outputs 0 within the same cycle, and the next branch after release behaves as in REQ-036.
